morse_char_buffer: RTL and testbench
====================================

Name: morse_char_buffer

Overview:
Parametrised character buffer for the Morse decoder display path. It accepts decoded character codes on rising edges of push, removes the newest character on backspace (with hold-to-repeat), and supports a synchronous clear. Contents are exported as a flat code vector plus per-slot valid mask for the downstream 7-segment mapping/scan logic. It generalises the fixed 8-slot, 4-bit shift store with configurable depth and code width, an occupancy count, full/empty/overflow status and a selectable overflow policy.

Parameters:
DEPTH, 8, number of character slots (>=2)
CODE_W, 5, bits per character code
SCROLL, 1, 1 = push when full discards oldest; 0 = push when full is dropped
REPEAT_DELAY, 50000000, cycles bksp must be held after its edge before the first auto-repeat; 0 disables auto-repeat
REPEAT_RATE, 12500000, cycles between subsequent auto-repeats while held (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
push  in  1  level; a rising edge requests storing din (synchronous, debounced upstream)
bksp  in  1  level; a rising edge, or a held level per the repeat rules, requests deletion of the newest char
clear  in  1  level; while high, the buffer empties every cycle
din  in  CODE_W  code captured on a push event
buf_out  out  DEPTH*CODE_W  slot i at bits [i*CODE_W +: CODE_W]; slot 0 = newest
valid  out  DEPTH  bit i = slot i holds a character
count  out  $clog2(DEPTH+1)  number of stored characters
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky; set by any push while full
changed  out  1  one-cycle pulse whenever buf_out/count changed this edge

Behaviour:
- Reset: buf_out=0, valid=0, count=0, full=0, empty=1, overflow=0, changed=0, edge registers=0, repeat counter idle.
- Edge detect: push_prev/bksp_prev registered each cycle. push_ev = push & ~push_prev. bksp_ev = bksp edge or repeat tick. Events act at the same clk edge that first samples the input high; outputs are visible after that edge (zero extra latency, all outputs registered).
- Priority per cycle: clear > bksp_ev > push_ev. Lower-priority events in the same cycle are discarded, not queued.
- Clear: all slots and valid bits zeroed, count=0, overflow=0; changed=1 only if count was nonzero.
- Push, not full: slots shift up (i <= i-1), slot 0 <= din, valid <= {valid[DEPTH-2:0],1}, count+1, changed=1.
- Push, full, SCROLL=1: same shift; the oldest slot (DEPTH-1) is lost; count stays DEPTH; overflow<=1; changed=1.
- Push, full, SCROLL=0: buffer unchanged; overflow<=1; changed=0.
- Backspace, not empty: slots shift down (i <= i+1), slot DEPTH-1 <= 0, valid <= valid>>1, count-1, changed=1.
- Backspace, empty: no-op, changed=0, no error flag.
- Invariant: valid == (1<<count)-1 at all times; invalid slots read 0.
- Auto-repeat (REPEAT_DELAY>0): the counter loads at the bksp edge. After bksp has been held REPEAT_DELAY consecutive cycles, one repeat event is issued, then one every REPEAT_RATE cycles while bksp stays high. Dropping bksp, asserting clear, or reset returns the counter to idle. Repeat ticks obey the same priority as edges.
- full/empty are derived from the registered count and change on the same edge as count.
- Reset asserted mid-hold or mid-repeat: all state returns to reset values immediately. After reset release with bksp already high, no edge occurs until bksp first goes low and then high again.

Test Plan:
- Reset, then push codes 1,2,3 (one edge each) -> buf_out[14:0]={3'd..}: slot0=3, slot1=2, slot2=1; count=3; valid=8'b0000_0111; changed pulses 3 times.
- DEPTH=8, SCROLL=1: push 9 codes 1..9 -> slot0=9, slot7=2; count=8; full=1; overflow=1. Repeat with SCROLL=0 -> slot0=8, slot7=1; 9th push gives changed=0.
- Fill 3, backspace edge -> slot0=2, slot1=1, slot2=0; count=2. Three further edges -> empty=1; 3rd is a no-op with changed=0.
- REPEAT_DELAY=10, REPEAT_RATE=4, 5 chars stored, bksp held 20 cycles -> deletions at the edge, edge+10, +14, +18; count=1.
- push and bksp rising in the same cycle with count=2 -> backspace only, count=1. clear with push in the same cycle -> count=0, overflow=0.
- Async rst pulsed mid-cycle while full and overflow=1 -> all outputs zero immediately and empty=1 without waiting for a clock. With bksp held through release, no deletion occurs.

Source files
------------

// File: rtl/morse_char_buffer.sv
// rtl/morse_char_buffer.sv - newest-first character store for the Morse display path
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   push            level; rising edge stores din into slot 0
//   bksp            level; rising edge (or auto-repeat while held) removes slot 0
//   clear           level; empties the buffer on every cycle it is high
//   din             character code captured on a push event
//   buf_out         slot i at [i*CODE_W +: CODE_W], slot 0 = newest
//   valid           bit i set when slot i holds a character
//   count           number of stored characters
//   full, empty     count == DEPTH, count == 0
//   overflow        sticky, set by any push while full, cleared by clear
//   changed         one-cycle pulse when buf_out/count changed on this edge
module morse_char_buffer #(
    parameter int DEPTH        = 8,
    parameter int CODE_W       = 5,
    parameter int SCROLL       = 1,
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 12500000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      bksp,
    input  logic                      clear,
    input  logic [CODE_W-1:0]         din,
    output logic [DEPTH*CODE_W-1:0]   buf_out,
    output logic [DEPTH-1:0]          valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      changed
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    logic [DEPTH*CODE_W-1:0] buf_q, buf_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    overflow_q, overflow_d;
    logic                    changed_q, changed_d;
    logic                    push_prev_q, bksp_prev_q;
    // bksp edges are only honoured once bksp has been seen low since reset,
    // so a key held through reset release does not delete a character.
    logic                    bksp_arm_q, bksp_arm_d;
    logic                    rpt_act_q, rpt_act_d;
    logic [RW-1:0]           rpt_cnt_q, rpt_cnt_d;

    logic push_ev, bksp_edge, rpt_tick, bksp_ev, is_full, is_empty;

    assign is_full   = (count_q == CW'(DEPTH));
    assign is_empty  = (count_q == '0);
    assign push_ev   = push & ~push_prev_q;
    assign bksp_edge = bksp & ~bksp_prev_q & bksp_arm_q;
    assign rpt_tick  = (REPEAT_DELAY > 0) && rpt_act_q && bksp && (rpt_cnt_q == '0);
    assign bksp_ev   = bksp_edge | rpt_tick;
    assign bksp_arm_d = bksp_arm_q | ~bksp;

    // Repeat counter: loaded with DELAY-1 at the edge so the first tick lands
    // exactly REPEAT_DELAY cycles after it; reloaded with RATE-1 on each tick.
    always_comb begin
        rpt_act_d = rpt_act_q;
        rpt_cnt_d = rpt_cnt_q;
        if (clear || !bksp || (REPEAT_DELAY == 0)) begin
            rpt_act_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (bksp_edge) begin
            rpt_act_d = 1'b1;
            rpt_cnt_d = RW'(REPEAT_DELAY - 1);
        end else if (rpt_act_q) begin
            if (rpt_cnt_q == '0) begin
                rpt_cnt_d = RW'(REPEAT_RATE - 1);
            end else begin
                rpt_cnt_d = rpt_cnt_q - RW'(1);
            end
        end
    end

    always_comb begin
        buf_d      = buf_q;
        valid_d    = valid_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        changed_d  = 1'b0;
        if (clear) begin
            buf_d      = '0;
            valid_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            changed_d  = !is_empty;
        end else if (bksp_ev) begin
            if (!is_empty) begin
                buf_d     = {{CODE_W{1'b0}}, buf_q[DEPTH*CODE_W-1:CODE_W]};
                valid_d   = valid_q >> 1;
                count_d   = count_q - CW'(1);
                changed_d = 1'b1;
            end
        end else if (push_ev) begin
            if (!is_full) begin
                buf_d     = {buf_q[(DEPTH-1)*CODE_W-1:0], din};
                valid_d   = {valid_q[DEPTH-2:0], 1'b1};
                count_d   = count_q + CW'(1);
                changed_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
                if (SCROLL != 0) begin
                    buf_d     = {buf_q[(DEPTH-1)*CODE_W-1:0], din};
                    changed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q       <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            changed_q   <= 1'b0;
            push_prev_q <= 1'b0;
            bksp_prev_q <= 1'b0;
            bksp_arm_q  <= 1'b0;
            rpt_act_q   <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            buf_q       <= buf_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            changed_q   <= changed_d;
            push_prev_q <= push;
            bksp_prev_q <= bksp;
            bksp_arm_q  <= bksp_arm_d;
            rpt_act_q   <= rpt_act_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign buf_out  = buf_q;
    assign valid    = valid_q;
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = is_empty;
    assign overflow = overflow_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_morse_char_buffer.sv
// tb/tb_morse_char_buffer.sv - scoreboard bench for morse_char_buffer (scroll and drop variants)
module tb_morse_char_buffer;

    localparam int DEPTH  = 8;
    localparam int CODE_W = 5;
    localparam int RD     = 10;
    localparam int RR     = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef struct packed {
        logic [DEPTH*CODE_W-1:0] b;
        logic [DEPTH-1:0]        v;
        logic [3:0]              c;
        logic                    f;
        logic                    e;
        logic                    o;
        logic                    ch;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push = 1'b0, bksp = 1'b0, clear = 1'b0;
    code_t din = '0;

    logic [DEPTH*CODE_W-1:0] bo [2];
    logic [DEPTH-1:0]        vl [2];
    logic [3:0]              cn [2];
    logic                    fu [2], em [2], ov [2], chg [2];

    morse_char_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W), .SCROLL(1),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_scroll (
        .clk(clk), .rst(rst), .push(push), .bksp(bksp), .clear(clear), .din(din),
        .buf_out(bo[0]), .valid(vl[0]), .count(cn[0]), .full(fu[0]), .empty(em[0]),
        .overflow(ov[0]), .changed(chg[0]));

    morse_char_buffer #(.DEPTH(DEPTH), .CODE_W(CODE_W), .SCROLL(0),
                        .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) u_drop (
        .clk(clk), .rst(rst), .push(push), .bksp(bksp), .clear(clear), .din(din),
        .buf_out(bo[1]), .valid(vl[1]), .count(cn[1]), .full(fu[1]), .empty(em[1]),
        .overflow(ov[1]), .changed(chg[1]));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: contents held as a newest-first queue.
    logic  m_pprev, m_bprev, m_arm, m_act;
    int    m_hold;
    code_t mq [2][$];
    logic  movf [2];
    obs_t  sb [2][$];

    function automatic obs_t actual(input int k);
        return {bo[k], vl[k], cn[k], fu[k], em[k], ov[k], chg[k]};
    endfunction

    task automatic cmp(input int k, input string nm, input obs_t a, input obs_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s dut%0d: got buf=%h valid=%b count=%0d f/e/o/ch=%b%b%b%b, expected buf=%h valid=%b count=%0d f/e/o/ch=%b%b%b%b",
                     nm, k, a.b, a.v, a.c, a.f, a.e, a.o, a.ch, e.b, e.v, e.c, e.f, e.e, e.o, e.ch);
        end
    endtask

    task automatic model_reset();
        m_pprev = 1'b0;
        m_bprev = 1'b0;
        m_arm   = 1'b0;
        m_act   = 1'b0;
        m_hold  = 0;
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            movf[k] = 1'b0;
        end
    endtask

    task automatic drive(input logic p, input logic b, input logic c, input code_t d);
        logic pe, be, tick, bev, ch;
        int   n;
        obs_t e;
        push = p; bksp = b; clear = c; din = d;
        pe = p && !m_pprev;
        be = b && !m_bprev && m_arm;
        // m_hold = cycles bksp has stayed high since its edge.
        if (c || !b) m_act = 1'b0;
        else if (be) begin m_act = 1'b1; m_hold = 0; end
        else if (m_act) m_hold++;
        tick = m_act && !be && (m_hold >= RD) && (((m_hold - RD) % RR) == 0);
        bev = be || tick;
        m_arm = m_arm || !b;
        m_pprev = p;
        m_bprev = b;
        for (int k = 0; k < 2; k++) begin
            n  = mq[k].size();
            ch = 1'b0;
            if (c) begin
                ch = (n > 0);
                mq[k].delete();
                movf[k] = 1'b0;
            end else if (bev) begin
                if (n > 0) begin
                    void'(mq[k].pop_front());
                    ch = 1'b1;
                end
            end else if (pe) begin
                if (n < DEPTH) begin
                    mq[k].push_front(d);
                    ch = 1'b1;
                end else begin
                    movf[k] = 1'b1;
                    if (k == 0) begin
                        void'(mq[k].pop_back());
                        mq[k].push_front(d);
                        ch = 1'b1;
                    end
                end
            end
            n = mq[k].size();
            e = '0;
            for (int i = 0; i < n; i++) e.b[i*CODE_W +: CODE_W] = mq[k][i];
            e.v  = DEPTH'((1 << n) - 1);
            e.c  = 4'(n);
            e.f  = (n == DEPTH);
            e.e  = (n == 0);
            e.o  = movf[k];
            e.ch = ch;
            sb[k].push_back(e);
        end
    endtask

    task automatic step(input logic p, input logic b, input logic c, input code_t d);
        @(negedge clk);
        #1;
        drive(p, b, c, d);
    endtask

    task automatic pushc(input code_t d);
        step(1'b1, 1'b0, 1'b0, d);
        step(1'b0, 1'b0, 1'b0, d);
    endtask

    task automatic bksp_edge();
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_clear();
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic check_reset(input string nm);
        obs_t r;
        r = '0;
        r.e = 1'b1;
        for (int k = 0; k < 2; k++) cmp(k, nm, actual(k), r);
    endtask

    // Monitor: every registered output set is checked one step after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (sb[k].size() > 0) begin
                    obs_t e;
                    e = sb[k].pop_front();
                    cmp(k, "cycle", actual(k), e);
                end
            end
        end
    end

    initial begin
        int   seg;
        logic bl;
        model_reset();
        #1;
        check_reset("reset_state");
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);

        // three pushes
        pushc(5'd1); pushc(5'd2); pushc(5'd3);

        // nine pushes: scroll keeps 9..2, drop keeps 8..1
        do_clear();
        for (int i = 1; i <= 9; i++) pushc(code_t'(i));

        // fill three, four backspace edges (last one on empty)
        do_clear();
        pushc(5'd1); pushc(5'd2); pushc(5'd3);
        for (int i = 0; i < 4; i++) bksp_edge();

        // auto-repeat: five chars, bksp held 20 cycles
        do_clear();
        for (int i = 1; i <= 5; i++) pushc(code_t'(i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // push and bksp rising together with count 2
        do_clear();
        pushc(5'd4); pushc(5'd5);
        step(1'b1, 1'b1, 1'b0, 5'd9);
        step(1'b0, 1'b0, 1'b0, '0);

        // clear together with push while full and overflowed
        for (int i = 0; i < 9; i++) pushc(code_t'(i + 10));
        step(1'b1, 1'b0, 1'b1, 5'd4);
        step(1'b0, 1'b0, 1'b0, '0);

        // randomized traffic
        seg = 0;
        bl  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (seg == 0) begin
                seg = $urandom_range(1, 25);
                bl  = ($urandom_range(0, 9) < 3);
            end
            seg--;
            step(1'($urandom_range(0, 1)), bl, ($urandom_range(0, 49) == 0), code_t'($urandom));
        end

        // async reset mid-cycle while full and overflowed, bksp held through release
        do_clear();
        for (int i = 0; i < 9; i++) pushc(code_t'(i + 20));
        @(posedge clk);
        #3;
        rst  = 1'b1;
        bksp = 1'b1;
        #1;
        check_reset("async_reset");
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd7);
        for (int i = 0; i < 20; i++) step(1'(i % 2), 1'b1, 1'b0, code_t'(i + 1));
        step(1'b0, 1'b0, 1'b0, '0);
        bksp_edge();

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
